alu_accumulator: RTL and testbench
==================================

ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port operand, input, 3 bits: signed two's-complement operand B, range -4..3.
REQ-004 SHALL have port op, input, 2 bits: 00 ADD, 01 SUB, 10 LOAD, 11 MUL.
REQ-005 SHALL have port go, input, 1 bit: level request; only its rising edge starts an operation.
REQ-006 SHALL have port s, output, 3 bits: registered accumulator value, feeds the 7-segment display stage.
REQ-007 SHALL have port ovfl, output, 1 bit: registered overflow flag of the last completed operation, feeds the display stage.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-010 SHALL keep a registered copy go_q of go; a rising edge is go=1 and go_q=0 at a clock edge.
REQ-011 SHALL implement states IDLE, EXEC, MUL, DONE; busy=1 in EXEC, MUL and DONE, else 0.
REQ-012 SHALL, in IDLE on a go rising edge, capture op and operand and move to MUL if op=11, else to EXEC.
REQ-013 SHALL ignore go edges while busy=1; no queuing.
REQ-014 SHALL spend exactly one cycle in EXEC, update s and ovfl at its end, then enter DONE.
REQ-015 SHALL spend exactly three cycles in MUL, one iteration of shift-add on operand magnitudes per cycle, with sign correction applied in the third; s and ovfl update at the end of the third cycle, then enter DONE.
REQ-016 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-017 SHALL give latency from the capturing edge to the s update of 1 cycle for ADD/SUB/LOAD and 3 cycles for MUL; done is high the cycle after the s update.
REQ-018 ADD/SUB SHALL compute in 4-bit sign-extended arithmetic; s = low 3 bits (wrap); ovfl=1 iff the true result lies outside -4..3.
REQ-019 LOAD SHALL set s=operand and ovfl=0.
REQ-020 MUL SHALL form the full 6-bit signed product; s = low 3 bits; ovfl=1 iff the product lies outside -4..3.
REQ-021 SHALL hold ovfl from one completed operation until the next operation completes.
REQ-022 SHALL keep s, ovfl and the accumulator unchanged while in IDLE.
REQ-023 SHALL use the accumulator (current s) as operand A for ADD, SUB and MUL.
REQ-024 SHALL treat a go edge in the DONE cycle as ignored; a request requires go to go low and then high again while in IDLE.

Reset
REQ-025 SHALL, while rst=1, immediately force state=IDLE, s=000, ovfl=0, busy=0, done=0 and go_q=1, independent of clk.
REQ-026 SHALL, with go_q reset to 1, start no operation if go is held high through reset release.
REQ-027 SHALL, on reset mid-EXEC or mid-MUL, abort the operation with no partial result visible after release.

Verification
REQ-028 SHALL cover: reset, op=10 operand=011, pulse go -> s=011, ovfl=0 one cycle after capture, done pulse the next cycle.
REQ-029 SHALL cover: s=011, op=00 operand=001 -> s=100, ovfl=1; then op=10 operand=000 -> ovfl=0.
REQ-030 SHALL cover: s=110 (-2), op=01 operand=011 -> s=011, ovfl=1; then s=110, op=01 operand=110 -> s=000, ovfl=0.
REQ-031 SHALL cover: s=111 (-1), op=11 operand=011 -> busy 3 cycles in MUL, s=101, ovfl=0; then s=110, op=11 operand=110 -> s=100, ovfl=1.
REQ-032 SHALL cover: go held high across reset release -> no done pulse; a second go edge during MUL -> ignored, exactly one done pulse.
REQ-033 SHALL cover: assert rst in the second MUL cycle -> s=000, ovfl=0, busy=0, done=0 before the next clk edge, and IDLE after release.

Source files
------------

// File: rtl/alu_accumulator.sv
// ALU accumulator: 3-bit signed accumulator with ADD/SUB/LOAD and a
// 3-cycle shift-add multiplier. Results feed the 7-segment display stage.
module alu_accumulator (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] operand,
  input  logic [1:0] op,
  input  logic       go,
  output logic [2:0] s,
  output logic       ovfl,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  logic [1:0] state;
  logic       go_q;
  logic [1:0] op_r;
  logic [2:0] b_r;
  logic [5:0] mcand;
  logic [2:0] mplr;
  logic [5:0] prod;
  logic       neg;
  logic [1:0] cnt;

  logic       rise;
  logic [3:0] a4;
  logic [3:0] b4;
  logic [3:0] sum4;
  logic [5:0] partial;
  logic [5:0] full;
  logic       mul_ovf;

  // Magnitude of a 3-bit signed value; -4 maps to unsigned 4.
  function automatic logic [2:0] mag(input logic [2:0] x);
    mag = x[2] ? 3'(-x) : x;
  endfunction

  // Edge detect, ADD/SUB datapath and one shift-add step.
  always_comb begin
    rise    = go & ~go_q;
    a4      = {s[2], s};
    b4      = {b_r[2], b_r};
    sum4    = (op_r == OP_SUB) ? (a4 - b4) : (a4 + b4);
    partial = prod + (mplr[0] ? mcand : 6'd0);
    full    = neg ? 6'(-partial) : partial;
    mul_ovf = ~((full[5:2] == 4'b0000) |
                (full[5:2] == 4'b1111));
  end

  // Control FSM, accumulator and multiplier state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      go_q  <= 1'b1;
      s     <= 3'd0;
      ovfl  <= 1'b0;
      op_r  <= 2'd0;
      b_r   <= 3'd0;
      mcand <= 6'd0;
      mplr  <= 3'd0;
      prod  <= 6'd0;
      neg   <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      go_q <= go;
      unique case (state)
        IDLE: begin
          if (rise) begin
            op_r  <= op;
            b_r   <= operand;
            mcand <= {3'd0, mag(s)};
            mplr  <= mag(operand);
            neg   <= s[2] ^ operand[2];
            prod  <= 6'd0;
            cnt   <= 2'd0;
            state <= (op == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          if (op_r == OP_LOAD) begin
            s    <= b_r;
            ovfl <= 1'b0;
          end else begin
            s    <= sum4[2:0];
            ovfl <= sum4[3] ^ sum4[2];
          end
          state <= DONE;
        end
        MUL: begin
          prod  <= partial;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'd2) begin
            s     <= full[2:0];
            ovfl  <= mul_ovf;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed testbench for alu_accumulator.
// Expected values are hand-computed per vector.
module tb_alu_accumulator;

  logic       clk;
  logic       rst;
  logic [2:0] operand;
  logic [1:0] op;
  logic       go;
  logic [2:0] s;
  logic       ovfl;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  alu_accumulator dut (
    .clk     (clk),
    .rst     (rst),
    .operand (operand),
    .op      (op),
    .go      (go),
    .s       (s),
    .ovfl    (ovfl),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation from IDLE and waits (bounded) for done.
  // Returns edges from capture to done, busy cycles before done,
  // and leaves the DUT in IDLE one edge after the done cycle.
  task automatic run_op(
    input  logic [1:0] o,
    input  logic [2:0] b,
    output int         lat,
    output int         bc,
    output logic [2:0] s_d,
    output logic       ov_d
  );
    logic seen;
    @(negedge clk);
    op = o;
    operand = b;
    go = 1'b1;
    @(posedge clk);
    #1;
    bc = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    s_d = 3'bxxx;
    ov_d = 1'bx;
    @(negedge clk);
    go = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat = i;
        s_d = s;
        ov_d = ovfl;
      end else if (busy) begin
        bc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op = 2'b00;
    operand = 3'b000;
    go = 1'b0;
    rst = 1'b1;
    #12;
    checks++;
    if (s !== 3'b000) begin
      failures++;
      $display("FAIL reset_s got=%b exp=000", s);
    end
    checks++;
    if ({ovfl, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000",
               {ovfl, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    int lat, bc;
    logic [2:0] sd;
    logic od;
    run_op(2'b10, 3'b011, lat, bc, sd, od);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL load_latency got=%0d exp=1", lat);
    end
    checks++;
    if ({sd, od} !== 4'b0110) begin
      failures++;
      $display("FAIL load_result got=%b exp=0110", {sd, od});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL load_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_addsub();
    int lat, bc;
    logic [2:0] sd;
    logic od;
    run_op(2'b10, 3'b011, lat, bc, sd, od);
    run_op(2'b00, 3'b001, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b1001) begin
      failures++;
      $display("FAIL add_3p1 got=%b exp=1001", {sd, od});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, ovfl} !== 4'b1001) begin
      failures++;
      $display("FAIL idle_hold got=%b exp=1001", {s, ovfl});
    end
    run_op(2'b10, 3'b000, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0000) begin
      failures++;
      $display("FAIL load_clr got=%b exp=0000", {sd, od});
    end
    run_op(2'b10, 3'b110, lat, bc, sd, od);
    run_op(2'b01, 3'b011, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0111) begin
      failures++;
      $display("FAIL sub_m2m3 got=%b exp=0111", {sd, od});
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL sub_latency got=%0d exp=1", lat);
    end
    run_op(2'b10, 3'b110, lat, bc, sd, od);
    run_op(2'b01, 3'b110, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0000) begin
      failures++;
      $display("FAIL sub_m2m2 got=%b exp=0000", {sd, od});
    end
    run_op(2'b10, 3'b100, lat, bc, sd, od);
    run_op(2'b00, 3'b100, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0001) begin
      failures++;
      $display("FAIL add_m4m4 got=%b exp=0001", {sd, od});
    end
    run_op(2'b10, 3'b101, lat, bc, sd, od);
    run_op(2'b00, 3'b010, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b1110) begin
      failures++;
      $display("FAIL add_m3p2 got=%b exp=1110", {sd, od});
    end
  endtask

  task automatic test_mul();
    int lat, bc;
    logic [2:0] sd;
    logic od;
    run_op(2'b10, 3'b111, lat, bc, sd, od);
    run_op(2'b11, 3'b011, lat, bc, sd, od);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL mul_latency got=%0d exp=3", lat);
    end
    checks++;
    if (bc !== 3) begin
      failures++;
      $display("FAIL mul_busy got=%0d exp=3", bc);
    end
    checks++;
    if ({sd, od} !== 4'b1010) begin
      failures++;
      $display("FAIL mul_m1p3 got=%b exp=1010", {sd, od});
    end
    run_op(2'b10, 3'b110, lat, bc, sd, od);
    run_op(2'b11, 3'b110, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b1001) begin
      failures++;
      $display("FAIL mul_m2m2 got=%b exp=1001", {sd, od});
    end
    run_op(2'b10, 3'b100, lat, bc, sd, od);
    run_op(2'b11, 3'b100, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0001) begin
      failures++;
      $display("FAIL mul_m4m4 got=%b exp=0001", {sd, od});
    end
    run_op(2'b10, 3'b011, lat, bc, sd, od);
    run_op(2'b11, 3'b111, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b1010) begin
      failures++;
      $display("FAIL mul_p3m1 got=%b exp=1010", {sd, od});
    end
    run_op(2'b10, 3'b010, lat, bc, sd, od);
    run_op(2'b11, 3'b011, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b1101) begin
      failures++;
      $display("FAIL mul_p2p3 got=%b exp=1101", {sd, od});
    end
  endtask

  task automatic test_go_rules();
    int pulses;
    int lat, bc;
    logic [2:0] sd;
    logic od;
    @(negedge clk);
    go = 1'b1;
    op = 2'b10;
    operand = 3'b010;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL go_held_rst got=%0d exp=0", pulses);
    end
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    run_op(2'b10, 3'b111, lat, bc, sd, od);
    @(negedge clk);
    op = 2'b11;
    operand = 3'b011;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL mul_go_ignored got=%0d exp=1", pulses);
    end
    checks++;
    if ({s, ovfl} !== 4'b1010) begin
      failures++;
      $display("FAIL mul_go_result got=%b exp=1010", {s, ovfl});
    end
  endtask

  task automatic test_rst_mid();
    int lat, bc;
    logic [2:0] sd;
    logic od;
    run_op(2'b10, 3'b011, lat, bc, sd, od);
    @(negedge clk);
    op = 2'b11;
    operand = 3'b011;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({s, ovfl, busy, done} !== 6'b000000) begin
      failures++;
      $display("FAIL rst_mid_mul got=%b exp=000000",
               {s, ovfl, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, ovfl, busy, done} !== 6'b000000) begin
      failures++;
      $display("FAIL rst_mid_after got=%b exp=000000",
               {s, ovfl, busy, done});
    end
    run_op(2'b10, 3'b010, lat, bc, sd, od);
    checks++;
    if ({sd, od} !== 4'b0100 || lat !== 1) begin
      failures++;
      $display("FAIL rst_recover got=%b lat=%0d exp=0100 lat=1",
               {sd, od}, lat);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    go = 1'b0;
    op = 2'b00;
    operand = 3'b000;
    test_reset();
    test_load();
    test_addsub();
    test_mul();
    test_go_rules();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
